// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : FIFO-buffered UART transmitter paced by a shared oversample tick;
//            frames go out LSB-first, back-to-back while bytes are queued.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               oversample_tick,
    input  logic [DATA_BITS-1:0]               tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               txd,
    output logic                               tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT  = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_LVL_W-1:0] c_FULL      = c_LVL_W'(FIFO_DEPTH);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Byte FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_count;
    logic                 r_active;

    // Frame engine
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_sample_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_txd;
    logic                 r_busy;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_has_data;
    logic                 w_stop_done;
    logic [DATA_BITS-1:0] w_head;
    logic [DATA_BITS-1:0] w_shift_next;

    // r_active holds tx_ready low through reset and for the reset-release edge.
    assign w_has_data   = (r_count != '0);
    assign tx_ready     = r_active && (r_count != c_FULL);
    assign w_push       = tx_valid && tx_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_shift_next = r_shift >> 1;
    assign w_stop_done  = (r_state == ST_STOP) && (r_sample_cnt == '0) &&
                          (r_stop_cnt == c_LAST_STOP);
    assign w_pop        = oversample_tick && w_has_data &&
                          ((r_state == ST_IDLE) || w_stop_done);

    assign txd        = r_txd;
    assign tx_busy    = r_busy;
    assign fifo_level = r_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_push) begin
                r_mem[r_wr_ptr] <= tx_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_LVL_W'(1);
                2'b01:   r_count <= r_count - c_LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else if (oversample_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift      <= w_head;
                        r_sample_cnt <= c_CNT_LOAD;
                        r_state      <= ST_START;
                        r_txd        <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (r_sample_cnt == '0) begin
                        r_sample_cnt <= c_CNT_LOAD;
                        r_bit_idx    <= '0;
                        r_state      <= ST_DATA;
                        r_txd        <= r_shift[0];
                    end else begin
                        r_sample_cnt <= r_sample_cnt - c_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_sample_cnt == '0) begin
                        r_sample_cnt <= c_CNT_LOAD;
                        r_shift      <= w_shift_next;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_stop_cnt <= 1'b0;
                            r_state    <= ST_STOP;
                            r_txd      <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            r_txd     <= w_shift_next[0];
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt - c_CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_sample_cnt == '0) begin
                        r_sample_cnt <= c_CNT_LOAD;
                        if (r_stop_cnt != c_LAST_STOP) begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end else if (w_has_data) begin
                            // Chain straight into the next start bit, no idle gap.
                            r_shift <= w_head;
                            r_state <= ST_START;
                            r_txd   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_sample_cnt <= r_sample_cnt - c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
